// File: rtl/int_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt request controller.
package int_pkg;

    localparam int NUM_SRC   = 3;
    localparam int ID_W      = 2;
    localparam int MAX_DEPTH = 4;
    localparam int DEPTH_W   = 3;

    localparam logic [ID_W-1:0] NO_INT    = '0;
    localparam logic [31:0]     VEC_BASE  = 32'h0000_3000;
    localparam int              VEC_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PUSH   = 2'd1,
        POP    = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Highest pending id; bit k of req is source id k+1, higher id wins.
    function automatic logic [ID_W-1:0] highest_id(input logic [NUM_SRC-1:0] req);
        logic [ID_W-1:0] id;
        id = NO_INT;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (req[k]) id = ID_W'(k + 1);
        end
        return id;
    endfunction

    // Vector address from a zero-extended id, computed in 32 bits.
    function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_BASE + ({{(32-ID_W){1'b0}}, id} << VEC_SHIFT);
    endfunction

endpackage

// File: rtl/int_req_ctrl_if.sv
// Bus between the CPU/stack side (master) and the interrupt request controller (slave).
interface int_req_ctrl_if
    import int_pkg::*;
();
    logic [NUM_SRC-1:0] irq_in;
    logic               ie;
    logic               int_allow;
    logic               eret;
    logic [ID_W-1:0]    cur_level;
    logic               take;
    logic [31:0]        vec_addr;
    logic               stack_en;
    logic               stack_sel;
    logic [ID_W-1:0]    stack_int_no;
    logic [NUM_SRC-1:0] pending;
    logic [DEPTH_W-1:0] depth;

    modport master (
        output irq_in, ie, int_allow, eret, cur_level,
        input  take, vec_addr, stack_en, stack_sel, stack_int_no, pending, depth
    );

    modport slave (
        input  irq_in, ie, int_allow, eret, cur_level,
        output take, vec_addr, stack_en, stack_sel, stack_int_no, pending, depth
    );
endinterface

// File: rtl/irq_edge_sync.sv
// Per-source synchroniser and rising-edge detect.
// Build macro IRQ_SYNC_EN: when defined a 2-flop synchroniser precedes the edge
// detect; otherwise irq_raw is assumed synchronous to clk.
module irq_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw,
    output logic rise
);
    logic line;
    logic prev_reg;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_reg;

    // Two-stage metastability guard for the asynchronous request line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg <= 2'b00;
        else        sync_reg <= {sync_reg[0], irq_raw};
    end

    assign line = sync_reg[1];
`else
    assign line = irq_raw;
`endif

    // Remember last sampled level so a 0->1 step can be recognised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_reg <= 1'b0;
        else        prev_reg <= line;
    end

    assign rise = line & ~prev_reg;
endmodule

// File: rtl/int_req_ctrl.sv
// Interrupt request controller: pending capture, fixed-priority arbitration against
// the current stack top, push/pop commands to the nesting stack and take/vector to the CPU.
// Build macro IRQ_SYNC_EN (inside irq_edge_sync) adds two cycles of input synchronisation.
module int_req_ctrl
    import int_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    int_req_ctrl_if.slave  bus
);
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [DEPTH_W-1:0] depth_reg, depth_next;
    state_t             state_reg, state_next;
    logic               take_reg, take_next;
    logic               stack_en_reg, stack_en_next;
    logic               stack_sel_reg, stack_sel_next;
    logic [ID_W-1:0]    int_no_reg, int_no_next;
    logic [31:0]        vec_reg, vec_next;
    logic [ID_W-1:0]    best;
    logic               accept;
    logic               do_pop;
    logic               do_push;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_edge_sync u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .irq_raw (bus.irq_in[gi]),
                .rise    (rise[gi])
            );
            // One-hot clear of the id being pushed this cycle.
            assign clr[gi] = do_push && (best == ID_W'(gi + 1));
        end
    endgenerate

    // Arbitration: eret wins over a new accept in the same IDLE cycle.
    always_comb begin
        best    = highest_id(pending_reg);
        accept  = bus.ie && bus.int_allow && (best != NO_INT) && (best > bus.cur_level)
                  && (depth_reg < DEPTH_W'(MAX_DEPTH));
        do_pop  = (state_reg == IDLE) && bus.eret && (depth_reg != '0);
        do_push = (state_reg == IDLE) && !do_pop && accept;
    end

    // Pending and depth bookkeeping; a new edge beats a same-cycle clear.
    always_comb begin
        pending_next = (pending_reg & ~clr) | rise;
        depth_next   = depth_reg;
        if (do_push && depth_reg < DEPTH_W'(MAX_DEPTH)) depth_next = depth_reg + 1'b1;
        else if (do_pop && depth_reg != '0)               depth_next = depth_reg - 1'b1;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (do_pop)       state_next = POP;
                else if (do_push) state_next = PUSH;
            end
            PUSH:    state_next = SETTLE;
            POP:     state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the state being entered, so outputs come straight from flops.
    always_comb begin
        take_next      = 1'b0;
        stack_en_next  = 1'b0;
        stack_sel_next = 1'b0;
        int_no_next    = NO_INT;
        vec_next       = '0;
        case (state_next)
            PUSH: begin
                take_next     = 1'b1;
                stack_en_next = 1'b1;
                int_no_next   = best;
                vec_next      = vec_of(best);
            end
            POP: begin
                stack_en_next  = 1'b1;
                stack_sel_next = 1'b1;
            end
            default: ;
        endcase
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            depth_reg     <= '0;
            take_reg      <= 1'b0;
            stack_en_reg  <= 1'b0;
            stack_sel_reg <= 1'b0;
            int_no_reg    <= NO_INT;
            vec_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            depth_reg     <= depth_next;
            take_reg      <= take_next;
            stack_en_reg  <= stack_en_next;
            stack_sel_reg <= stack_sel_next;
            int_no_reg    <= int_no_next;
            vec_reg       <= vec_next;
        end
    end

    assign bus.take         = take_reg;
    assign bus.stack_en     = stack_en_reg;
    assign bus.stack_sel    = stack_sel_reg;
    assign bus.stack_int_no = int_no_reg;
    assign bus.vec_addr     = vec_reg;
    assign bus.pending      = pending_reg;
    assign bus.depth        = depth_reg;
endmodule

// File: tb/tb_int_req_ctrl.sv
// Self-checking bench for int_req_ctrl: table-driven transactions plus hand-written
// sequences for full stack, underflow, masking, eret/accept collision and reset mid-push.
module tb_int_req_ctrl;
    import int_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int_req_ctrl_if bus_if ();

    int_req_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Behavioural nesting stack supplying cur_level, with an override for corner cases.
    logic [ID_W-1:0] stk [0:7];
    int              stk_ptr;
    logic [ID_W-1:0] stk_top;
    logic            force_en;
    logic [ID_W-1:0] cur_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stk_ptr <= 0;
        else if (bus_if.stack_en) begin
            if (!bus_if.stack_sel) begin
                if (stk_ptr < 8) begin
                    stk[stk_ptr] <= bus_if.stack_int_no;
                    stk_ptr      <= stk_ptr + 1;
                end
            end else if (stk_ptr > 0) begin
                stk_ptr <= stk_ptr - 1;
            end
        end
    end

    always_comb begin
        stk_top = '0;
        if (stk_ptr > 0 && stk_ptr <= 8) stk_top = stk[stk_ptr-1];
    end

    assign bus_if.cur_level = force_en ? cur_force : stk_top;

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic tk, input logic en, input logic sel,
                           input logic [ID_W-1:0] no, input logic [31:0] vec,
                           input logic [NUM_SRC-1:0] pend, input logic [DEPTH_W-1:0] dep);
        chk({tag, ".take"},      32'(bus_if.take),         32'(tk));
        chk({tag, ".stack_en"},  32'(bus_if.stack_en),     32'(en));
        chk({tag, ".stack_sel"}, 32'(bus_if.stack_sel),    32'(sel));
        chk({tag, ".int_no"},    32'(bus_if.stack_int_no), 32'(no));
        chk({tag, ".vec_addr"},  bus_if.vec_addr,          vec);
        chk({tag, ".pending"},   32'(bus_if.pending),      32'(pend));
        chk({tag, ".depth"},     32'(bus_if.depth),        32'(dep));
    endtask

    typedef struct {
        logic [NUM_SRC-1:0] irq;
        logic               eret;
        int                 w;      // cycles from stimulus to check; 0 = request latency
        logic               tk;
        logic               en;
        logic               sel;
        logic [ID_W-1:0]    no;
        logic [31:0]        vec;
        logic [NUM_SRC-1:0] pend;
        logic [DEPTH_W-1:0] dep;
    } row_t;

    row_t rows [9];

    initial begin
        int w;
        logic seen_en;

        rows[0] = '{3'b001, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h3004, 3'b000, 3'd1}; // single request
        rows[1] = '{3'b000, 1'b1, 1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,    3'b000, 3'd0}; // eret pop
        rows[2] = '{3'b101, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h300C, 3'b001, 3'd1}; // id3 beats id1
        rows[3] = '{3'b000, 1'b1, 1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,    3'b001, 3'd0}; // pop, id1 waits
        rows[4] = '{3'b000, 1'b0, 1, 1'b1, 1'b1, 1'b0, 2'd1, 32'h3004, 3'b000, 3'd1}; // id1 after pop
        rows[5] = '{3'b000, 1'b1, 1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0,    3'b000, 3'd0}; // pop
        rows[6] = '{3'b010, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'd2, 32'h3008, 3'b000, 3'd1}; // level 2
        rows[7] = '{3'b001, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,    3'b001, 3'd1}; // masked id1
        rows[8] = '{3'b100, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2'd3, 32'h300C, 3'b001, 3'd2}; // nest id3

        rst_n            = 1'b0;
        force_en         = 1'b0;
        cur_force        = '0;
        bus_if.irq_in    = '0;
        bus_if.ie        = 1'b1;
        bus_if.int_allow = 1'b1;
        bus_if.eret      = 1'b0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 32'h0, 3'b000, 3'd0);
        rst_n = 1'b1;
        step();
        step();

        for (int i = 0; i < 9; i++) begin
            w = (rows[i].w == 0) ? LAT : rows[i].w;
            bus_if.irq_in = rows[i].irq;
            bus_if.eret   = rows[i].eret;
            step();
            bus_if.eret = 1'b0;
            for (int k = 1; k < w; k++) begin
                if (k == w - 1) begin
                    chk($sformatf("row%0d.early_take", i), 32'(bus_if.take), 32'h0);
                end
                step();
            end
            chk_all($sformatf("row%0d", i), rows[i].tk, rows[i].en, rows[i].sel, rows[i].no,
                    rows[i].vec, rows[i].pend, rows[i].dep);
            $display("row %0d: irq=%b eret=%b take=%b en=%b sel=%b no=%0d vec=%h pend=%b depth=%0d",
                     i, rows[i].irq, rows[i].eret, bus_if.take, bus_if.stack_en, bus_if.stack_sel,
                     bus_if.stack_int_no, bus_if.vec_addr, bus_if.pending, bus_if.depth);
            bus_if.irq_in = '0;
            step();
            step();
        end

        // Stack full: force level 0 so pending id1 and a new id2 fill depth to 4.
        force_en  = 1'b1;
        cur_force = '0;
        step();
        chk_all("full.push1", 1, 1, 0, 2'd1, 32'h3004, 3'b000, 3'd3);
        step();
        step();
        bus_if.irq_in = 3'b010;
        repeat (LAT) step();
        chk_all("full.push2", 1, 1, 0, 2'd2, 32'h3008, 3'b000, 3'd4);
        bus_if.irq_in = '0;
        step();
        step();
        bus_if.irq_in = 3'b100;
        seen_en = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            step();
            if (bus_if.stack_en) seen_en = 1'b1;
        end
        bus_if.irq_in = '0;
        chk("full.no_strobe", 32'(seen_en), 32'h0);
        chk("full.pending", 32'(bus_if.pending), 32'h4);
        chk("full.depth", 32'(bus_if.depth), 32'h4);
        $display("full: depth=%0d pending=%b strobe_seen=%b", bus_if.depth, bus_if.pending, seen_en);
        bus_if.eret = 1'b1;
        step();
        bus_if.eret = 1'b0;
        chk_all("full.pop", 0, 1, 1, 2'd0, 32'h0, 3'b100, 3'd3);
        step();
        step();
        step();
        chk_all("full.refill", 1, 1, 0, 2'd3, 32'h300C, 3'b000, 3'd4);
        step();
        step();

        // Plain reset while idle with a full stack.
        rst_n = 1'b0;
        #1;
        chk_all("rst_idle", 0, 0, 0, 0, 32'h0, 3'b000, 3'd0);
        step();
        rst_n    = 1'b1;
        force_en = 1'b0;
        step();

        // Reset asserted while PUSH is on the outputs.
        bus_if.irq_in = 3'b001;
        repeat (LAT) step();
        chk("rstpush.take_before", 32'(bus_if.take), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_all("rstpush", 0, 0, 0, 0, 32'h0, 3'b000, 3'd0);
        bus_if.irq_in = '0;
        step();
        step();
        rst_n   = 1'b1;
        seen_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus_if.stack_en) seen_en = 1'b1;
        end
        chk("rstpush.no_strobe_after", 32'(seen_en), 32'h0);
        $display("reset mid-push: depth=%0d strobe_after=%b", bus_if.depth, seen_en);

        // eret at depth 0 is ignored.
        bus_if.eret = 1'b1;
        step();
        bus_if.eret = 1'b0;
        seen_en = bus_if.stack_en;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus_if.stack_en) seen_en = 1'b1;
        end
        chk("underflow.no_strobe", 32'(seen_en), 32'h0);
        chk("underflow.depth", 32'(bus_if.depth), 32'h0);
        $display("underflow: depth=%0d strobe_seen=%b", bus_if.depth, seen_en);

        // Global enable masks; request stays pending and is taken once ie returns.
        bus_if.ie     = 1'b0;
        bus_if.irq_in = 3'b001;
        seen_en = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            if (bus_if.take) seen_en = 1'b1;
        end
        chk("ie_off.no_take", 32'(seen_en), 32'h0);
        chk("ie_off.pending", 32'(bus_if.pending), 32'h1);
        bus_if.ie     = 1'b1;
        bus_if.irq_in = '0;
        step();
        chk_all("ie_on", 1, 1, 0, 2'd1, 32'h3004, 3'b000, 3'd1);
        $display("ie mask: take after enable=%b depth=%0d", bus_if.take, bus_if.depth);
        step();
        step();

        // eret and accept in the same IDLE cycle: POP first, then PUSH.
        bus_if.irq_in = 3'b100;
        repeat (LAT - 1) step();
        chk("collide.pending", 32'(bus_if.pending), 32'h4);
        bus_if.eret = 1'b1;
        step();
        bus_if.eret = 1'b0;
        chk_all("collide.pop", 0, 1, 1, 2'd0, 32'h0, 3'b100, 3'd0);
        step();
        chk_all("collide.settle", 0, 0, 0, 2'd0, 32'h0, 3'b100, 3'd0);
        step();
        chk("collide.idle_take", 32'(bus_if.take), 32'h0);
        step();
        chk_all("collide.push", 1, 1, 0, 2'd3, 32'h300C, 3'b000, 3'd1);
        $display("collide: push id=%0d depth=%0d", bus_if.stack_int_no, bus_if.depth);
        bus_if.irq_in = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
